// File: rtl/bip_acc_datapath_if.sv
// Control-unit <-> accumulator datapath bus for the BIP core.
// The control unit drives through the master modport and the datapath answers through the slave modport.
interface bip_acc_datapath_if #(
    parameter int DATA_W    = 16,
    parameter int OPERAND_W = 11
);
    logic [1:0]           sel_a;
    logic                 sel_b;
    logic                 wr_acc;
    logic [2:0]           op;
    logic [OPERAND_W-1:0] operand;
    logic [DATA_W-1:0]    in_memory_data;
    logic                 mul_start;
    logic [DATA_W-1:0]    out_memory_data;
    logic                 flag_z;
    logic                 flag_n;
    logic                 flag_c;
    logic                 flag_v;
    logic                 busy;
    logic                 done;

    modport master (
        output sel_a, sel_b, wr_acc, op, operand, in_memory_data, mul_start,
        input  out_memory_data, flag_z, flag_n, flag_c, flag_v, busy, done
    );

    modport slave (
        input  sel_a, sel_b, wr_acc, op, operand, in_memory_data, mul_start,
        output out_memory_data, flag_z, flag_n, flag_c, flag_v, busy, done
    );
endinterface

// File: rtl/bip_acc_datapath.sv
// BIP accumulator datapath: ACC loads, ALU with registered Z/N/C/V flags.
// Define BIP_MUL_EN to build the iterative shift-add multiplier (mul_start/busy/done).
module bip_acc_datapath #(
    parameter int DATA_W    = 16,
    parameter int OPERAND_W = 11,
    parameter bit SIGN_EXT  = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    bip_acc_datapath_if.slave bus
);
    typedef enum logic [2:0] {
        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL1, OP_SAR1, OP_PASSB
    } alu_op_e;

    typedef enum logic [1:0] {SRC_MEM, SRC_IMM, SRC_ALU, SRC_ZERO} acc_src_e;

    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] ext_imm;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] alu_res;
    logic [DATA_W-1:0] src_val;
    logic [DATA_W-1:0] wb_val;
    logic [DATA_W:0]   add_full;
    logic [DATA_W:0]   sub_full;
    logic              flag_z, flag_n, flag_c, flag_v;
    logic              alu_c, alu_v, alu_c_upd, alu_v_upd;
    logic              wb_en, wb_alu;

    // NOTE: every always_comb output gets a default first so no path can leave it unassigned (no latch).
    always_comb begin
        ext_imm = (SIGN_EXT && bus.operand[OPERAND_W-1]) ? '1 : '0;
        ext_imm[OPERAND_W-1:0] = bus.operand;
    end

    assign b        = bus.sel_b ? ext_imm : bus.in_memory_data;
    assign add_full = {1'b0, acc} + {1'b0, b};
    assign sub_full = {1'b0, acc} - {1'b0, b};

    always_comb begin
        alu_res   = b;
        alu_c     = 1'b0;
        alu_v     = 1'b0;
        alu_c_upd = 1'b0;
        alu_v_upd = 1'b0;
        case (alu_op_e'(bus.op))
            OP_ADD: begin
                alu_res   = add_full[DATA_W-1:0];
                alu_c     = add_full[DATA_W];
                alu_v     = (acc[DATA_W-1] == b[DATA_W-1]) && (add_full[DATA_W-1] != acc[DATA_W-1]);
                alu_c_upd = 1'b1;
                alu_v_upd = 1'b1;
            end
            OP_SUB: begin
                // Carry is "no borrow": set when ACC >= B unsigned.
                alu_res   = sub_full[DATA_W-1:0];
                alu_c     = ~sub_full[DATA_W];
                alu_v     = (acc[DATA_W-1] != b[DATA_W-1]) && (sub_full[DATA_W-1] != acc[DATA_W-1]);
                alu_c_upd = 1'b1;
                alu_v_upd = 1'b1;
            end
            OP_AND: alu_res = acc & b;
            OP_OR:  alu_res = acc | b;
            OP_XOR: alu_res = acc ^ b;
            OP_SHL1: begin
                alu_res   = {acc[DATA_W-2:0], 1'b0};
                alu_c     = acc[DATA_W-1];
                alu_c_upd = 1'b1;
            end
            OP_SAR1: begin
                alu_res   = {acc[DATA_W-1], acc[DATA_W-1:1]};
                alu_c     = acc[0];
                alu_c_upd = 1'b1;
            end
            default: alu_res = b;
        endcase
    end

    always_comb begin
        src_val = '0;
        case (acc_src_e'(bus.sel_a))
            SRC_MEM:  src_val = bus.in_memory_data;
            SRC_IMM:  src_val = ext_imm;
            SRC_ALU:  src_val = alu_res;
            default:  src_val = '0;
        endcase
    end

`ifdef BIP_MUL_EN
    typedef enum logic {ST_IDLE, ST_MUL} state_e;

    localparam int                STEP_W    = $clog2(DATA_W);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(DATA_W - 1);

    state_e            state;
    logic [DATA_W-1:0] mcand;
    logic [DATA_W-1:0] mplier;
    logic [DATA_W-1:0] prod;
    logic [DATA_W-1:0] prod_next;
    logic [STEP_W-1:0] step;
    logic              busy_q;
    logic              done_q;

    // Product is kept to DATA_W bits; higher bits are dropped as the multiplicand shifts out.
    assign prod_next = prod + (mplier[0] ? mcand : '0);

    // NOTE: sequential state is assigned with <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            mcand  <= '0;
            mplier <= '0;
            prod   <= '0;
            step   <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.mul_start) begin
                        mcand  <= acc;
                        mplier <= b;
                        prod   <= '0;
                        step   <= '0;
                        busy_q <= 1'b1;
                        state  <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    prod   <= prod_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    step   <= step + 1'b1;
                    if (step == LAST_STEP) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // The multiplier owns the ACC write port while running; start beats a same-cycle wr_acc.
    always_comb begin
        wb_en  = 1'b0;
        wb_alu = 1'b0;
        wb_val = src_val;
        if (state == ST_MUL) begin
            wb_en  = (step == LAST_STEP);
            wb_val = prod_next;
        end else begin
            wb_en  = bus.wr_acc && !bus.mul_start;
            wb_alu = (acc_src_e'(bus.sel_a) == SRC_ALU);
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
`else
    logic unused_mul_start;
    assign unused_mul_start = bus.mul_start;

    always_comb begin
        wb_en  = bus.wr_acc;
        wb_val = src_val;
        wb_alu = (acc_src_e'(bus.sel_a) == SRC_ALU);
    end

    assign bus.busy = 1'b0;
    assign bus.done = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            acc    <= '0;
            flag_z <= 1'b0;
            flag_n <= 1'b0;
            flag_c <= 1'b0;
            flag_v <= 1'b0;
        end else if (wb_en) begin
            acc    <= wb_val;
            flag_z <= (wb_val == '0);
            flag_n <= wb_val[DATA_W-1];
            if (wb_alu && alu_c_upd) flag_c <= alu_c;
            if (wb_alu && alu_v_upd) flag_v <= alu_v;
        end
    end

    assign bus.out_memory_data = acc;
    assign bus.flag_z          = flag_z;
    assign bus.flag_n          = flag_n;
    assign bus.flag_c          = flag_c;
    assign bus.flag_v          = flag_v;
endmodule

// File: tb/tb_bip_acc_datapath.sv
// Self-checking bench for bip_acc_datapath: directed vector table, random run against an
// arithmetic reference model, and multiplier / disabled-multiplier sequences (BIP_MUL_EN).
module tb_bip_acc_datapath;
    localparam int MASK = 32'h0000_FFFF;

    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    bip_acc_datapath_if #(.DATA_W(16), .OPERAND_W(11)) bus ();
    bip_acc_datapath_if #(.DATA_W(16), .OPERAND_W(11)) bus_zx ();

    bip_acc_datapath #(.DATA_W(16), .OPERAND_W(11), .SIGN_EXT(1'b1)) u_dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    // Zero-extending twin driven by the same stimulus.
    bip_acc_datapath #(.DATA_W(16), .OPERAND_W(11), .SIGN_EXT(1'b0)) u_dut_zx (
        .clk(clk), .rst(rst), .bus(bus_zx)
    );

    assign bus_zx.sel_a          = bus.sel_a;
    assign bus_zx.sel_b          = bus.sel_b;
    assign bus_zx.wr_acc         = bus.wr_acc;
    assign bus_zx.op             = bus.op;
    assign bus_zx.operand        = bus.operand;
    assign bus_zx.in_memory_data = bus.in_memory_data;
    assign bus_zx.mul_start      = bus.mul_start;

    typedef struct {
        logic [1:0]  sel_a;
        logic        sel_b;
        logic [2:0]  op;
        logic [10:0] operand;
        logic [15:0] mem;
        logic        wr;
        logic [15:0] exp_acc;
        logic [3:0]  exp_flags;   // {z, n, c, v}
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    // Reference model state
    int m_acc;
    bit m_z, m_n, m_c, m_v;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [1:0] sa, input logic sb, input logic [2:0] opv,
                                input logic [10:0] imm, input logic [15:0] mem, input logic wr,
                                input logic [15:0] ea, input logic [3:0] ef);
        vec_t v;
        v.sel_a = sa; v.sel_b = sb; v.op = opv; v.operand = imm; v.mem = mem; v.wr = wr;
        v.exp_acc = ea; v.exp_flags = ef;
        return v;
    endfunction

    function automatic logic [3:0] dut_flags();
        return {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v};
    endfunction

    function automatic int sgn(input int x);
        return (x >= 32768) ? x - 65536 : x;
    endfunction

    function automatic int ext11(input int imm);
        return (imm >= 1024) ? imm + 32'h0000_F800 : imm;
    endfunction

    // Behavioural model: plain integer arithmetic on the instruction semantics.
    task automatic model_step(input int sa, input int sb, input int opv, input int imm,
                              input int mem, input bit wr);
        int bv, res, sres, val;
        bit c, v, cu, vu;
        bv = sb ? ext11(imm) : mem;
        c = 0; v = 0; cu = 0; vu = 0; res = bv;
        case (opv)
            0: begin
                res = m_acc + bv; c = (res > MASK);
                sres = sgn(m_acc) + sgn(bv); v = (sres > 32767) || (sres < -32768);
                cu = 1; vu = 1;
            end
            1: begin
                res = m_acc - bv; c = (m_acc >= bv);
                sres = sgn(m_acc) - sgn(bv); v = (sres > 32767) || (sres < -32768);
                cu = 1; vu = 1;
            end
            2: res = m_acc & bv;
            3: res = m_acc | bv;
            4: res = m_acc ^ bv;
            5: begin res = m_acc * 2; c = (m_acc >= 32768); cu = 1; end
            6: begin res = sgn(m_acc) >>> 1; c = (m_acc % 2) == 1; cu = 1; end
            default: res = bv;
        endcase
        res = res & MASK;
        if (wr) begin
            case (sa)
                0: val = mem;
                1: val = ext11(imm);
                2: val = res;
                default: val = 0;
            endcase
            m_acc = val;
            m_z = (val == 0);
            m_n = (val >= 32768);
            if (sa == 2 && cu) m_c = c;
            if (sa == 2 && vu) m_v = v;
        end
    endtask

    task automatic idle_inputs();
        bus.sel_a = 2'd0; bus.sel_b = 1'b0; bus.wr_acc = 1'b0; bus.op = 3'd0;
        bus.operand = '0; bus.in_memory_data = '0; bus.mul_start = 1'b0;
    endtask

    task automatic reset_dut();
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic apply(input logic [1:0] sa, input logic sb, input logic [2:0] opv,
                         input logic [10:0] imm, input logic [15:0] mem, input logic wr);
        bus.sel_a = sa; bus.sel_b = sb; bus.op = opv; bus.operand = imm;
        bus.in_memory_data = mem; bus.wr_acc = wr; bus.mul_start = 1'b0;
        @(negedge clk);
    endtask

`ifdef BIP_MUL_EN
    // Leaves C=1, V=1 before loading a, so the multiply must hold both.
    task automatic mul_run(input logic [15:0] a, input logic [15:0] bm, input int abort_at,
                           input string tag);
        int busy_cnt, done_cnt, done_at, hold_err;
        logic [15:0] acc_at_done, exp_p;
        logic [3:0]  flags_at_done;
        busy_cnt = 0; done_cnt = 0; done_at = 0; hold_err = 0;
        acc_at_done = '0; flags_at_done = '0;
        exp_p = 16'((longint'(a) * longint'(bm)) & 64'hFFFF);
        reset_dut();
        apply(2'd0, 1'b0, 3'd0, 11'h000, 16'h8000, 1'b1);
        apply(2'd2, 1'b1, 3'd1, 11'h001, 16'h0000, 1'b1);
        apply(2'd0, 1'b0, 3'd0, 11'h000, a, 1'b1);
        // Start with a concurrent zero-load that must be ignored.
        bus.sel_a = 2'd3; bus.sel_b = 1'b0; bus.in_memory_data = bm;
        bus.wr_acc = 1'b1; bus.mul_start = 1'b1;
        @(negedge clk);
        for (int k = 1; k <= 40; k++) begin
            if (bus.busy) begin
                busy_cnt++;
                if (bus.out_memory_data !== a) hold_err++;
            end
            if (bus.done) begin
                done_cnt++; done_at = k;
                acc_at_done = bus.out_memory_data; flags_at_done = dut_flags();
            end
            if (abort_at != 0 && k == abort_at + 1) begin
                check({tag, " abort acc"}, 32'(bus.out_memory_data), 32'h0);
                check({tag, " abort busy"}, 32'(bus.busy), 32'h0);
            end
            bus.sel_a = 2'd1; bus.operand = 11'h055;
            bus.wr_acc = (k <= 16) ? 1'(k % 2) : 1'b0;
            bus.mul_start = (k == 3);
            rst = (abort_at != 0 && k == abort_at);
            @(negedge clk);
        end
        rst = 1'b0;
        idle_inputs();
        if (abort_at != 0) begin
            check({tag, " abort done cnt"}, 32'(done_cnt), 32'd0);
        end else begin
            check({tag, " busy cycles"}, 32'(busy_cnt), 32'd16);
            check({tag, " done cnt"}, 32'(done_cnt), 32'd1);
            check({tag, " done cycle"}, 32'(done_at), 32'd17);
            check({tag, " acc hold"}, 32'(hold_err), 32'd0);
            check({tag, " product"}, 32'(acc_at_done), 32'(exp_p));
            check({tag, " flags"}, 32'(flags_at_done), 32'({exp_p == 16'h0, exp_p[15], 1'b1, 1'b1}));
        end
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = mk(2'd1, 1'b0, 3'd0, 11'h400, 16'h0000, 1'b1, 16'hFC00, 4'b0100);
        vecs[1]  = mk(2'd0, 1'b0, 3'd0, 11'h000, 16'h7FFF, 1'b1, 16'h7FFF, 4'b0000);
        vecs[2]  = mk(2'd2, 1'b1, 3'd0, 11'h001, 16'h0000, 1'b1, 16'h8000, 4'b0101);
        vecs[3]  = mk(2'd0, 1'b0, 3'd0, 11'h000, 16'h0005, 1'b1, 16'h0005, 4'b0001);
        vecs[4]  = mk(2'd2, 1'b0, 3'd1, 11'h000, 16'h0005, 1'b1, 16'h0000, 4'b1010);
        vecs[5]  = mk(2'd0, 1'b0, 3'd0, 11'h000, 16'h8002, 1'b1, 16'h8002, 4'b0110);
        vecs[6]  = mk(2'd2, 1'b0, 3'd6, 11'h000, 16'h0000, 1'b1, 16'hC001, 4'b0100);
        vecs[7]  = mk(2'd3, 1'b0, 3'd0, 11'h000, 16'h0000, 1'b0, 16'hC001, 4'b0100);
        vecs[8]  = mk(2'd2, 1'b0, 3'd5, 11'h000, 16'h0000, 1'b1, 16'h8002, 4'b0110);
        vecs[9]  = mk(2'd2, 1'b1, 3'd2, 11'h3FF, 16'h0000, 1'b1, 16'h0002, 4'b0010);
        vecs[10] = mk(2'd2, 1'b0, 3'd4, 11'h000, 16'h0002, 1'b1, 16'h0000, 4'b1010);
        vecs[11] = mk(2'd2, 1'b1, 3'd0, 11'h7FF, 16'h0000, 1'b1, 16'hFFFF, 4'b0100);
        vecs[12] = mk(2'd2, 1'b0, 3'd0, 11'h000, 16'h0001, 1'b1, 16'h0000, 4'b1010);
        vecs[13] = mk(2'd2, 1'b1, 3'd1, 11'h001, 16'h0000, 1'b1, 16'hFFFF, 4'b0100);
        vecs[14] = mk(2'd2, 1'b0, 3'd1, 11'h000, 16'h7FFF, 1'b1, 16'h8000, 4'b0110);
        vecs[15] = mk(2'd2, 1'b1, 3'd1, 11'h001, 16'h0000, 1'b1, 16'h7FFF, 4'b0011);
        vecs[16] = mk(2'd2, 1'b0, 3'd3, 11'h000, 16'h8000, 1'b1, 16'hFFFF, 4'b0111);
        vecs[17] = mk(2'd2, 1'b0, 3'd7, 11'h000, 16'h1234, 1'b1, 16'h1234, 4'b0011);
        vecs[18] = mk(2'd3, 1'b0, 3'd0, 11'h000, 16'h0000, 1'b1, 16'h0000, 4'b1011);
        vecs[19] = mk(2'd1, 1'b0, 3'd0, 11'h123, 16'h0000, 1'b1, 16'h0123, 4'b0011);

        // Reset holds ACC at zero even with a load requested.
        idle_inputs();
        rst = 1'b1;
        bus.wr_acc = 1'b1; bus.sel_a = 2'd1; bus.operand = 11'h155;
        @(negedge clk);
        @(negedge clk);
        check("reset acc", 32'(bus.out_memory_data), 32'h0);
        check("reset flags", 32'(dut_flags()), 32'h0);
        check("reset busy/done", 32'({bus.busy, bus.done}), 32'h0);
        rst = 1'b0;
        idle_inputs();
        @(negedge clk);

        for (int i = 0; i < NV; i++) begin
            apply(vecs[i].sel_a, vecs[i].sel_b, vecs[i].op, vecs[i].operand, vecs[i].mem, vecs[i].wr);
            check($sformatf("vec%0d acc", i), 32'(bus.out_memory_data), 32'(vecs[i].exp_acc));
            check($sformatf("vec%0d flags", i), 32'(dut_flags()), 32'(vecs[i].exp_flags));
            if (i == 0)
                check("zero-ext imm", 32'({bus_zx.out_memory_data, bus_zx.flag_n}), 32'({16'h0400, 1'b0}));
        end

        // Reset from a state with every flag source nonzero.
        reset_dut();
        check("re-reset acc", 32'(bus.out_memory_data), 32'h0);
        check("re-reset flags", 32'(dut_flags()), 32'h0);

        m_acc = 0; m_z = 0; m_n = 0; m_c = 0; m_v = 0;
        for (int i = 0; i < 400; i++) begin
            int sa, sb, opv, imm, mem;
            bit wr;
            sa  = $urandom_range(0, 3);
            sb  = $urandom_range(0, 1);
            opv = $urandom_range(0, 7);
            imm = $urandom_range(0, 2047);
            mem = $urandom_range(0, 65535);
            case ($urandom_range(0, 7))
                0: mem = 16'h7FFF;
                1: mem = 16'h8000;
                2: mem = 16'hFFFF;
                3: mem = m_acc;
                default: ;
            endcase
            if (sa == 1 || sa == 3) sa = ($urandom_range(0, 2) == 0) ? sa : 2;
            wr = ($urandom_range(0, 4) != 0);
            apply(2'(sa), 1'(sb), 3'(opv), 11'(imm), 16'(mem), wr);
            model_step(sa, sb, opv, imm, mem, wr);
            check($sformatf("rnd%0d acc", i), 32'(bus.out_memory_data), 32'(m_acc));
            check($sformatf("rnd%0d flags", i), 32'(dut_flags()), 32'({m_z, m_n, m_c, m_v}));
        end

`ifdef BIP_MUL_EN
        mul_run(16'd300, 16'd7, 0, "mul 300x7");
        mul_run(16'h1234, 16'h0567, 0, "mul trunc");
        mul_run(16'hFFFF, 16'hFFFF, 0, "mul ffff");
        mul_run(16'h0005, 16'h0000, 0, "mul zero");
        mul_run(16'd300, 16'd7, 5, "mul abort");
`else
        begin
            int busy_cnt, done_cnt, acc_err;
            busy_cnt = 0; done_cnt = 0; acc_err = 0;
            reset_dut();
            apply(2'd0, 1'b0, 3'd0, 11'h000, 16'h00AB, 1'b1);
            bus.wr_acc = 1'b0; bus.in_memory_data = 16'd7; bus.mul_start = 1'b1;
            @(negedge clk);
            bus.mul_start = 1'b0;
            for (int k = 0; k < 20; k++) begin
                if (bus.busy) busy_cnt++;
                if (bus.done) done_cnt++;
                if (bus.out_memory_data !== 16'h00AB) acc_err++;
                @(negedge clk);
            end
            check("nomul busy", 32'(busy_cnt), 32'd0);
            check("nomul done", 32'(done_cnt), 32'd0);
            check("nomul acc", 32'(acc_err), 32'd0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
